// File: rtl/div_pkg.sv
// Shared definitions for the programmable clock divider: FSM encoding,
// minimum legal ratio and default ratio width.
package div_pkg;

  localparam int W_DEF   = 8;
  localparam int DIV_MIN = 2;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_t;

endpackage

// File: rtl/div_core.sv
// Period counter and registered clk_out/tick decode. The outputs are decoded
// from next-cycle count and ratio so they line up with the registered count.
module div_core
  import div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         act_i,
  input  logic         run_i,
  input  logic [W-1:0] div_now_i,
  input  logic [W-1:0] div_nxt_i,
  output logic         wrap_o,
  output logic         clk_out_o,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         clk_out_q;
  logic         tick_q;

  // High phase length ceil(n/2) computed without widening past W bits.
  function automatic logic [W-1:0] half_up(input logic [W-1:0] n);
    return (n >> 1) + {{(W-1){1'b0}}, n[0]};
  endfunction

  assign wrap_o = (cnt_q == (div_now_i - W'(1)));

  always_comb begin
    cnt_d = '0;
    if (run_i && act_i && !wrap_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= run_i && (cnt_d < half_up(div_nxt_i));
      tick_q    <= run_i && (cnt_d == (div_nxt_i - W'(1)));
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/div_sched.sv
// Divider scheduler: run/stop FSM and ratio handshake. New ratios and stops
// only take effect at a period boundary so clk_out never produces a runt.
module div_sched
  import div_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int DIV_RST = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic         clk_out,
  output logic         tick
);

  if (DIV_RST < DIV_MIN) begin : g_bad_div_rst
    $error("div_sched: DIV_RST must be at least %0d", DIV_MIN);
  end

  state_t       state_q, state_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_q, pend_d;
  logic         err_q, err_d;
  logic         wrap;
  logic         xfer;
  logic         bad;

  assign cfg_ready = (state_q != ST_PEND);
  assign xfer      = cfg_valid && cfg_ready;
  assign bad       = (cfg_div < W'(DIV_MIN));

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    err_d     = xfer && bad;
    case (state_q)
      ST_OFF: begin
        if (xfer && !bad) cur_div_d = cfg_div;
        if (en) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (xfer && !bad) begin
          pend_d  = cfg_div;
          state_d = ST_PEND;
        end
        // A stop wins at the boundary; an accepted ratio is applied rather than lost.
        if (wrap && !en) begin
          state_d = ST_OFF;
          if (xfer && !bad) cur_div_d = cfg_div;
        end
      end
      ST_PEND: begin
        if (wrap) begin
          cur_div_d = pend_q;
          state_d   = en ? ST_RUN : ST_OFF;
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_OFF;
      cur_div_q <= W'(DIV_RST);
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_div_q <= cur_div_d;
      err_q     <= err_d;
    end
    pend_q <= pend_d;
  end

  div_core #(.W(W)) u_core (
    .clk_i     (clk),
    .rst_i     (rst),
    .act_i     (state_q != ST_OFF),
    .run_i     (state_d != ST_OFF),
    .div_now_i (cur_div_q),
    .div_nxt_i (cur_div_d),
    .wrap_o    (wrap),
    .clk_out_o (clk_out),
    .tick_o    (tick)
  );

  assign cur_div = cur_div_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched: a per-cycle behavioural model predicts the
// outputs after every edge; a negedge monitor compares them against the DUT.
module tb_div_sched;

  localparam int W       = 8;
  localparam int DIV_RST = 3;

  logic         clk = 1'b0;
  logic         rst, en, cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready, cfg_err, clk_out, tick;
  logic [W-1:0] cur_div;

  typedef struct {
    logic       clk_out;
    logic       tick;
    logic       ready;
    logic       err;
    int         div;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model state: running flag, position in period, ratio, optional pending ratio.
  bit m_run, m_pendv, m_err;
  int m_pos, m_div, m_pend;

  always #5 clk = ~clk;

  div_sched #(.W(W), .DIV_RST(DIV_RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  function automatic void chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_step();
    exp_t e;
    bit   xfer, bad, newp, last;
    if (rst) begin
      m_run = 0; m_pos = 0; m_div = DIV_RST; m_pendv = 0; m_err = 0;
    end else begin
      xfer  = cfg_valid && !m_pendv;
      bad   = (int'(cfg_div) < 2);
      newp  = xfer && !bad;
      m_err = xfer && bad;
      if (!m_run) begin
        if (newp) m_div = int'(cfg_div);
        if (en) begin m_run = 1; m_pos = 0; end
      end else begin
        last = (m_pos == m_div - 1);
        if (!last) begin
          m_pos++;
          if (newp) begin m_pendv = 1; m_pend = int'(cfg_div); end
        end else begin
          m_pos = 0;
          if (m_pendv) begin m_div = m_pend; m_pendv = 0; end
          if (!en) begin
            m_run = 0;
            if (newp) m_div = int'(cfg_div);
          end else if (newp) begin
            m_pendv = 1; m_pend = int'(cfg_div);
          end
        end
      end
    end
    e.clk_out = m_run && (m_pos < (m_div + 1) / 2);
    e.tick    = m_run && (m_pos == m_div - 1);
    e.ready   = !m_pendv;
    e.err     = m_err;
    e.div     = m_div;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wait_tick();
    int n = 0;
    while (!tick && n < 600) begin
      cyc();
      n++;
    end
    chk("tick_seen", int'(tick), 1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("clk_out",   int'(clk_out),   int'(e.clk_out));
      chk("tick",      int'(tick),      int'(e.tick));
      chk("cfg_ready", int'(cfg_ready), int'(e.ready));
      chk("cfg_err",   int'(cfg_err),   int'(e.err));
      chk("cur_div",   int'(cur_div),   e.div);
    end
  end

  initial begin
    int hi, tk, last_tk;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    en = 1'b1;
    repeat (10) cyc();

    // Ratio change mid-period.
    wait_tick();
    cyc();
    cfg_valid = 1'b1; cfg_div = 8'd4;
    cyc();
    cfg_valid = 1'b0;
    repeat (14) cyc();
    chk("cur_div_after_change", int'(cur_div), 4);

    // Back to 3, then a rejected ratio.
    cfg_valid = 1'b1; cfg_div = 8'd3;
    cyc();
    cfg_valid = 1'b0;
    repeat (10) cyc();
    cfg_valid = 1'b1; cfg_div = 8'd1;
    cyc();
    cfg_valid = 1'b0;
    repeat (8) cyc();
    chk("cur_div_after_reject", int'(cur_div), 3);

    // Stop requested at count 0 with N=5.
    cfg_valid = 1'b1; cfg_div = 8'd5;
    cyc();
    cfg_valid = 1'b0;
    wait_tick();
    cyc();
    wait_tick();
    cyc();
    en = 1'b0;
    repeat (10) cyc();
    chk("off_clk_out", int'(clk_out), 0);

    // Reset while a ratio is pending.
    en = 1'b1;
    repeat (3) cyc();
    cfg_valid = 1'b1; cfg_div = 8'd6;
    cyc();
    cfg_valid = 1'b0;
    chk("pend_ready", int'(cfg_ready), 0);
    rst = 1'b1;
    cyc();
    chk("rst_cur_div", int'(cur_div), DIV_RST);
    chk("rst_ready",   int'(cfg_ready), 1);
    chk("rst_clk_out", int'(clk_out), 0);
    rst = 1'b0;
    repeat (12) cyc();
    chk("rst_release_div", int'(cur_div), DIV_RST);

    // Largest ratio: 128 high, 127 low, one tick per 255 cycles.
    en = 1'b0;
    repeat (8) cyc();
    cfg_valid = 1'b1; cfg_div = 8'd255;
    cyc();
    cfg_valid = 1'b0; en = 1'b1;
    cyc();
    wait_tick();
    hi = 0; tk = 0; last_tk = 0;
    for (int i = 0; i < 255; i++) begin
      cyc();
      hi += int'(clk_out);
      tk += int'(tick);
      last_tk = int'(tick);
    end
    chk("n255_high_cycles", hi, 128);
    chk("n255_tick_count",  tk, 1);
    chk("n255_tick_last",   last_tk, 1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      en        = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = W'($urandom_range(0, 9));
      cyc();
    end
    rst = 1'b0; cfg_valid = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
